cv32e40x_wb_stage_mp: RTL
=========================

Name: cv32e40x_wb_stage_mp

Overview:
- Parametrised successor writeback stage for CV32E40X. Sits after EX/WB and drives NUM_WPORTS register-file write ports.
- Adds an XIF_DEPTH-entry coprocessor result FIFO, so XIF results may arrive before their instruction reaches WB.
- Checks each result ID against the instruction ID.
- Keeps LSU status and watchpoint capture sticky until WB completes.

Parameters:
NUM_WPORTS, 2, RF write ports (1 or 2); port k writes the pair register
XIF_DEPTH, 2, coprocessor result FIFO entries (1..4)
X_ID_WIDTH, 4, XIF instruction ID width
DW, 32*NUM_WPORTS, writeback data width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ex_instr_valid_i  in  1  EX/WB entry valid
ex_lsu_en_i / ex_xif_en_i  in  1  instruction is LSU / XIF
ex_xif_id_i  in  X_ID_WIDTH  offloaded instruction ID
ex_rf_we_i  in  1  RF write requested
ex_rf_waddr_i  in  5  destination register
ex_rf_wdata_i  in  DW  ALU/CSR result
ex_last_op_i / ex_abort_op_i  in  1  sequence markers
kill_wb_i / halt_wb_i  in  1  controller kill / halt
lsu_valid_i  in  1  LSU response valid
lsu_rdata_i  in  DW  load data
lsu_status_i  in  2  bit0 MPU error, bit1 misaligned error
lsu_wpt_match_i  in  32  watchpoint match
lsu_valid_o / lsu_ready_o  out  1  LSU handshake
xif_result_valid_i  in  1  result valid
xif_result_ready_o  out  1  result accepted
xif_result_id_i  in  X_ID_WIDTH  result ID
xif_result_data_i  in  DW  result data
xif_result_exc_i  in  1  synchronous exception
rf_we_o  out  NUM_WPORTS  per-port write enable
rf_waddr_o  out  5*NUM_WPORTS  per-port address
rf_wdata_o  out  DW  write data
wb_valid_o / wb_ready_o  out  1  stage valid / ready
data_stall_o  out  1  waiting on LSU
last_op_o / abort_op_o  out  1  sequence control
lsu_status_wb_o  out  2  sticky LSU status
wpt_match_wb_o  out  32  sticky watchpoint
xif_id_err_o  out  1  head ID differs from instruction ID

Behaviour:
- Reset: FIFO empty, sticky flops cleared. Outputs: xif_result_ready_o=1, rf_we_o=0, wb_valid_o=0, xif_id_err_o=0, lsu_status_wb_o=0, wpt_match_wb_o=0.
- instr_valid = ex_instr_valid_i & !kill_wb_i & !halt_wb_i.
- Sticky LSU capture:
  - Capture on lsu_valid_i while not (wb_valid | kill_wb_i).
  - Clear on wb_valid | kill_wb_i. Clear has priority over capture.
  - The effective value is the flop value when its valid bit is set, else the live input.
- FIFO:
  - xif_result_ready_o = !full.
  - Push when valid & ready. Pop when wb_valid & ex_xif_en_i & head sourced from FIFO.
  - Simultaneous push and pop: both occur, count unchanged.
  - Pointers wrap modulo XIF_DEPTH.
- Bypass: if FIFO empty and xif_result_valid_i with ID equal to ex_xif_id_i while the XIF instruction is valid, the result is consumed the same cycle (zero latency) and not pushed.
- xif_avail: FIFO head (or bypass) present with ID match.
- xif_waiting = ex_instr_valid_i & ex_xif_en_i & !xif_avail.
- xif_id_err_o = ex_instr_valid_i & ex_xif_en_i & head present & ID mismatch. The entry is not consumed; the stage stalls.
- kill_wb_i flushes the whole FIFO the same cycle; a push in that cycle is discarded. Killed instructions never receive results.
- Write enables:
  - rf_we_o[k] = ex_rf_we_i & instr_valid & !lsu_err & !(|wpt) & !xif_waiting & !xif_exc.
  - rf_waddr_o[k] = {waddr[4:1], waddr[0]^k}.
- rf_wdata_o priority: LSU data, then XIF data, then ex_rf_wdata_i.
- wb_valid = instr_valid & ((!lsu_en & !xif_waiting) | (lsu_en & lsu_valid_eff)).
- wb_ready_o = kill_wb_i | (!xif_waiting & !halt_wb_i).
- lsu_valid_o = ex_lsu_en_i & ex_instr_valid_i; lsu_ready_o = 1.
- abort_op_o = ex_abort_op_i | (lsu_en & (lsu_err | |wpt)).
- data_stall_o = lsu_en & !lsu_valid_eff & instr_valid.

Decomposition:
- Package cv32e40x_pkg: LSU status bit constants, xif_res_entry_t {id, data, exc}.
- Sub-module cv32e40x_xif_res_fifo (parametrised depth/width): push/pop/flush, head, count.

Test Plan:
- ALU instr, rf_we=1, waddr=5, wdata=0xA5A5: rf_we_o=2'b11, addrs 5/4, wb_valid=1 same cycle.
- Load held by halt_wb: lsu_valid_i pulse with wpt=0x1. After halt drops, wpt_match_wb_o=0x1, abort_op_o=1, rf_we_o=0.
- XIF results id 3 and 4 pushed before instructions arrive: FIFO full at depth 2, ready=0. Instrs 3 then 4 retire on consecutive cycles, ready returns to 1.
- Empty FIFO, instr id 7 valid, result id 7 arrives: bypassed with wb_valid the same cycle, count stays 0.
- Head id 2 vs instr id 5: xif_id_err_o=1, wb_valid=0. Then kill_wb_i: FIFO empty, err=0.
- rst asserted with 1 queued entry and sticky status set: next cycle, count=0, outputs at reset values.

Source files
------------

// File: rtl/cv32e40x_pkg.sv
// Shared definitions for the multi-port writeback stage: LSU status bit
// positions and the coprocessor result entry layout.
package cv32e40x_pkg;

  localparam int LSU_STATUS_MPU_ERR      = 0;
  localparam int LSU_STATUS_MISALIGN_ERR = 1;

  localparam int XIF_ID_WIDTH_DEF = 4;
  localparam int XIF_DW_DEF       = 64;

  // Reference layout; the stage packs {exc, id, data} with its own widths
  typedef struct packed {
    logic                        exc;
    logic [XIF_ID_WIDTH_DEF-1:0] id;
    logic [XIF_DW_DEF-1:0]       data;
  } xif_res_entry_t;

endpackage

// File: rtl/cv32e40x_xif_res_fifo.sv
// Small circular FIFO holding coprocessor results that arrive before their
// instruction reaches writeback. Flush empties it in one cycle.
module cv32e40x_xif_res_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 69
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             head,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push & !full;
  assign do_pop  = pop & (count != '0);
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= next_ptr(wptr);
      if (do_pop)  rptr <= next_ptr(rptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage carries no reset; entries are only read while count says valid
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/cv32e40x_wb_stage_mp.sv
// Multi-port writeback stage: RF write ports, coprocessor result FIFO with
// same-cycle bypass, and sticky LSU status/watchpoint capture.
module cv32e40x_wb_stage_mp
  import cv32e40x_pkg::*;
#(
  parameter int NUM_WPORTS = 2,
  parameter int XIF_DEPTH  = 2,
  parameter int X_ID_WIDTH = 4,
  parameter int DW         = 32*NUM_WPORTS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ex_instr_valid_i,
  input  logic                    ex_lsu_en_i,
  input  logic                    ex_xif_en_i,
  input  logic [X_ID_WIDTH-1:0]   ex_xif_id_i,
  input  logic                    ex_rf_we_i,
  input  logic [4:0]              ex_rf_waddr_i,
  input  logic [DW-1:0]           ex_rf_wdata_i,
  input  logic                    ex_last_op_i,
  input  logic                    ex_abort_op_i,
  input  logic                    kill_wb_i,
  input  logic                    halt_wb_i,
  input  logic                    lsu_valid_i,
  input  logic [DW-1:0]           lsu_rdata_i,
  input  logic [1:0]              lsu_status_i,
  input  logic [31:0]             lsu_wpt_match_i,
  output logic                    lsu_valid_o,
  output logic                    lsu_ready_o,
  input  logic                    xif_result_valid_i,
  output logic                    xif_result_ready_o,
  input  logic [X_ID_WIDTH-1:0]   xif_result_id_i,
  input  logic [DW-1:0]           xif_result_data_i,
  input  logic                    xif_result_exc_i,
  output logic [NUM_WPORTS-1:0]   rf_we_o,
  output logic [5*NUM_WPORTS-1:0] rf_waddr_o,
  output logic [DW-1:0]           rf_wdata_o,
  output logic                    wb_valid_o,
  output logic                    wb_ready_o,
  output logic                    data_stall_o,
  output logic                    last_op_o,
  output logic                    abort_op_o,
  output logic [1:0]              lsu_status_wb_o,
  output logic [31:0]             wpt_match_wb_o,
  output logic                    xif_id_err_o
);

  localparam int EW    = 1 + X_ID_WIDTH + DW;
  localparam int CNT_W = $clog2(XIF_DEPTH+1);

  logic                  instr_valid;
  logic                  wb_valid;

  logic                  lsu_valid_q;
  logic [DW-1:0]         lsu_rdata_q;
  logic [1:0]            lsu_status_q;
  logic [31:0]           lsu_wpt_q;
  logic                  lsu_valid_eff;
  logic [DW-1:0]         lsu_rdata_eff;
  logic [1:0]            lsu_status_eff;
  logic [31:0]           lsu_wpt_eff;
  logic                  lsu_err;
  logic                  wpt_hit;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [EW-1:0]         fifo_head;
  logic                  head_exc;
  logic [X_ID_WIDTH-1:0] head_id;
  logic [DW-1:0]         head_data;

  logic                  xif_instr;
  logic                  bypass;
  logic                  head_match;
  logic                  xif_avail;
  logic                  xif_waiting;
  logic                  xif_exc;
  logic [DW-1:0]         xif_data;
  logic                  rf_we_common;

  assign instr_valid = ex_instr_valid_i & !kill_wb_i & !halt_wb_i;

  // Sticky LSU response: held until the instruction leaves WB or is killed
  always_ff @(posedge clk) begin
    if (rst) begin
      lsu_valid_q  <= 1'b0;
      lsu_rdata_q  <= '0;
      lsu_status_q <= '0;
      lsu_wpt_q    <= '0;
    end else if (wb_valid || kill_wb_i) begin
      lsu_valid_q  <= 1'b0;
      lsu_status_q <= '0;
      lsu_wpt_q    <= '0;
    end else if (lsu_valid_i) begin
      lsu_valid_q  <= 1'b1;
      lsu_rdata_q  <= lsu_rdata_i;
      lsu_status_q <= lsu_status_i;
      lsu_wpt_q    <= lsu_wpt_match_i;
    end
  end

  assign lsu_valid_eff  = lsu_valid_q | lsu_valid_i;
  assign lsu_rdata_eff  = lsu_valid_q ? lsu_rdata_q  : lsu_rdata_i;
  assign lsu_status_eff = lsu_valid_q ? lsu_status_q : lsu_status_i;
  assign lsu_wpt_eff    = lsu_valid_q ? lsu_wpt_q    : lsu_wpt_match_i;
  assign lsu_err        = lsu_status_eff[LSU_STATUS_MPU_ERR] | lsu_status_eff[LSU_STATUS_MISALIGN_ERR];
  assign wpt_hit        = |lsu_wpt_eff;

  cv32e40x_xif_res_fifo #(
    .DEPTH (XIF_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (kill_wb_i),
    .wdata ({xif_result_exc_i, xif_result_id_i, xif_result_data_i}),
    .head  (fifo_head),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign {head_exc, head_id, head_data} = fifo_head;
  assign fifo_empty = (fifo_count == '0);

  // Bypass only for a retirable instruction so a halted one never drops its result
  assign xif_instr   = ex_instr_valid_i & ex_xif_en_i;
  assign bypass      = fifo_empty & xif_result_valid_i & (xif_result_id_i == ex_xif_id_i)
                       & instr_valid & ex_xif_en_i;
  assign head_match  = !fifo_empty & (head_id == ex_xif_id_i);
  assign xif_avail   = head_match | bypass;
  assign xif_waiting = xif_instr & !xif_avail;
  assign xif_id_err_o = xif_instr & !fifo_empty & (head_id != ex_xif_id_i);
  assign xif_data    = bypass ? xif_result_data_i : head_data;
  assign xif_exc     = ex_xif_en_i & xif_avail & (bypass ? xif_result_exc_i : head_exc);

  assign xif_result_ready_o = !fifo_full;
  assign fifo_push = xif_result_valid_i & !fifo_full & !bypass & !kill_wb_i;
  assign fifo_pop  = wb_valid & ex_xif_en_i & !fifo_empty;

  assign wb_valid = instr_valid & ((!ex_lsu_en_i & !xif_waiting) | (ex_lsu_en_i & lsu_valid_eff));
  assign rf_we_common = ex_rf_we_i & instr_valid & !lsu_err & !wpt_hit & !xif_waiting & !xif_exc;

  for (genvar k = 0; k < NUM_WPORTS; k++) begin : g_port
    assign rf_we_o[k]          = rf_we_common;
    assign rf_waddr_o[5*k +: 5] = {ex_rf_waddr_i[4:1], ex_rf_waddr_i[0] ^ ((k % 2) == 1)};
  end

  always_comb begin
    rf_wdata_o = ex_rf_wdata_i;
    if (ex_lsu_en_i && lsu_valid_eff) rf_wdata_o = lsu_rdata_eff;
    else if (ex_xif_en_i && xif_avail) rf_wdata_o = xif_data;
  end

  assign wb_valid_o      = wb_valid;
  assign wb_ready_o      = kill_wb_i | (!xif_waiting & !halt_wb_i);
  assign lsu_valid_o     = ex_lsu_en_i & ex_instr_valid_i;
  assign lsu_ready_o     = 1'b1;
  assign last_op_o       = ex_last_op_i;
  assign abort_op_o      = ex_abort_op_i | (ex_lsu_en_i & (lsu_err | wpt_hit));
  assign data_stall_o    = ex_lsu_en_i & !lsu_valid_eff & instr_valid;
  assign lsu_status_wb_o = lsu_status_eff;
  assign wpt_match_wb_o  = lsu_wpt_eff;

endmodule
